// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Definitions shared by the UART command sequencer and its timer:
//   - host opcodes (first byte of every frame)
//   - response bytes returned through the UART transmitter
//   - sequencer state encoding
//   - a helper that checks an address byte against the bank address width
// ----------------------------------------------------------------------------
package ctrl_pkg;

  // Host opcodes
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  // Response bytes
  localparam logic [7:0] RSP_ACK  = 8'hAA;
  localparam logic [7:0] RSP_PING = 8'h55;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_RESP,
    ST_TX_HI,
    ST_TX_LO
  } state_e;

  // True when no address bit at or above position aw is set.
  function automatic logic addr_fits(input logic [7:0] addr, input int unsigned aw);
    logic fits;
    if (aw >= 8) begin
      fits = 1'b1;
    end else begin
      fits = ((addr >> aw) == 8'h00);
    end
    return fits;
  endfunction

endpackage

// File: rtl/cmd_timer.sv
// ----------------------------------------------------------------------------
// cmd_timer
// Inter-byte timeout counter for the command sequencer.
//   clk       in   system clock
//   nRst      in   asynchronous active-low reset
//   clear_i   in   restart the count (a byte was received); wins over expiry
//   enable_i  in   count this cycle (sequencer is waiting inside a frame)
//   expire_o  out  combinational: count has reached TIMEOUT-1 while enabled
//                  and not being cleared in the same cycle
// ----------------------------------------------------------------------------
module cmd_timer #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      // Wrap to zero on expiry so the next frame starts from a clean count
      // even if the sequencer leaves the waiting states without a new byte.
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl
// Parses host command frames from the UART receiver, performs one access on
// the weight register bank and answers with a single byte through the UART
// transmitter.
//   Frames: WRITE 0x01,addr,data -> 0xAA   READ 0x02,addr -> bank data
//           PING  0x03           -> 0x55   anything else  -> 0xEE + cmd_err
//
// Ports
//   clk         in   system clock
//   nRst        in   asynchronous active-low reset
//   rx_data     in   received byte (valid while rx_valid)
//   rx_valid    in   one-cycle pulse per received byte
//   tx_data     out  response byte, held until the transmitter finishes
//   tx_start    out  one-cycle transmit request, only while tx_busy=0
//   tx_busy     in   transmitter busy
//   bank_addr   out  bank address
//   bank_wdata  out  bank write data
//   bank_we     out  one-cycle bank write strobe
//   bank_re     out  one-cycle bank read strobe
//   bank_rdata  in   bank read data, valid one cycle after bank_re
//   cmd_err     out  one-cycle pulse on bad opcode/address, timeout or a
//                    byte dropped while the sequencer was busy
// ----------------------------------------------------------------------------
module uart_cmd_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [7:0]        bank_wdata,
  output logic              bank_we,
  output logic              bank_re,
  input  logic [7:0]        bank_rdata,
  output logic              cmd_err
);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
  logic [7:0]        bank_wdata_q, bank_wdata_d;
  logic              cmd_err_q, cmd_err_d;

  logic timer_en;
  logic timer_expire;

  // The timeout only runs while the sequencer is waiting for the next byte
  // of a frame; every received byte restarts it.
  assign timer_en = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

  cmd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .nRst     (nRst),
    .clear_i  (rx_valid),
    .enable_i (timer_en),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    tx_data_d    = tx_data_q;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    cmd_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          op_d = rx_data;
          if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
            state_d = ST_GET_ADDR;
          end else if (rx_data == OP_PING) begin
            tx_data_d = RSP_PING;
            state_d   = ST_RESP;
          end else begin
            tx_data_d = RSP_ERR;
            cmd_err_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end

      ST_GET_ADDR: begin
        if (rx_valid) begin
          addr_d = rx_data;
          if (op_q == OP_WRITE) begin
            // Address is only judged once the data byte has arrived.
            state_d = ST_GET_DATA;
          end else if (addr_fits(rx_data, ADDR_W)) begin
            bank_addr_d = rx_data[ADDR_W-1:0];
            state_d     = ST_RD;
          end else begin
            tx_data_d = RSP_ERR;
            cmd_err_d = 1'b1;
            state_d   = ST_RESP;
          end
        end else if (timer_expire) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_GET_DATA: begin
        if (rx_valid) begin
          if (addr_fits(addr_q, ADDR_W)) begin
            bank_addr_d  = addr_q[ADDR_W-1:0];
            bank_wdata_d = rx_data;
            state_d      = ST_WR;
          end else begin
            tx_data_d = RSP_ERR;
            cmd_err_d = 1'b1;
            state_d   = ST_RESP;
          end
        end else if (timer_expire) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_WR: begin
        tx_data_d = RSP_ACK;
        state_d   = ST_RESP;
      end

      ST_RD: begin
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        tx_data_d = bank_rdata;
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        if (!tx_busy) begin
          state_d = ST_TX_HI;
        end
      end

      ST_TX_HI: begin
        if (tx_busy) begin
          state_d = ST_TX_LO;
        end
      end

      ST_TX_LO: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bytes arriving while a frame is being executed or answered are lost;
    // flag them so the host knows to resend.
    if (rx_valid && (state_q != ST_IDLE) && (state_q != ST_GET_ADDR) &&
        (state_q != ST_GET_DATA)) begin
      cmd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= ST_IDLE;
      op_q         <= 8'h00;
      addr_q       <= 8'h00;
      tx_data_q    <= 8'h00;
      bank_addr_q  <= '0;
      bank_wdata_q <= 8'h00;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      tx_data_q    <= tx_data_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  // Strobes are decoded from the state register: each strobe state lasts
  // exactly one cycle, so each strobe is a single-cycle pulse, and reset
  // forces IDLE so they drop immediately.
  assign bank_we    = (state_q == ST_WR);
  assign bank_re    = (state_q == ST_RD);
  // Gating with tx_busy means the request fires on the first free cycle in
  // RESP and can never overlap a busy transmitter.
  assign tx_start   = (state_q == ST_RESP) && !tx_busy;

  assign tx_data    = tx_data_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Frames are generated (directed, then random) and their expected response
// byte, response latency, bank writes and error counts are derived from the
// frame rules with a plain memory array. A monitor on the falling edge pops
// the expectations whenever the design strobes tx_start or bank_we.
// ----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              nRst = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [ADDR_W-1:0] bank_addr;
  logic [7:0]        bank_wdata;
  logic              bank_we;
  logic              bank_re;
  logic [7:0]        bank_rdata;
  logic              cmd_err;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_we    (bank_we),
    .bank_re    (bank_re),
    .bank_rdata (bank_rdata),
    .cmd_err    (cmd_err)
  );

  // ---------------- environment: transmitter and bank ----------------
  int   uart_cnt = 0;
  logic force_busy = 1'b0;
  assign tx_busy = (uart_cnt != 0) || force_busy;

  always @(posedge clk) begin
    if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    else if (tx_start) uart_cnt <= int'($urandom_range(1, 4));
  end

  logic       mem_clr = 1'b1;
  logic [7:0] tb_mem [16];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 8'h00;
      bank_rdata <= 8'h00;
    end else begin
      if (bank_we) tb_mem[bank_addr] <= bank_wdata;
      if (bank_re) bank_rdata <= tb_mem[bank_addr];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] resp;
    int         mode;  // 1: latency from last byte, 2: first cycle after busy falls
    int         lat;
  } exp_t;
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  logic [7:0] ref_mem [16];
  int exp_err = 0;
  int exp_re  = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, act, act, req, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int   ncyc = 0;
  int   last_rx = -1000;
  int   last_busy = -1000;
  int   last_err = -1000;
  int   err_seen = 0;
  int   re_seen = 0;
  int   start_cnt = 0;
  exp_t mon_e;
  wr_t  mon_w;

  always @(negedge clk) begin
    ncyc++;
    if (tx_busy) last_busy = ncyc;
    if (rx_valid) last_rx = ncyc;
    if (nRst) begin
      if (bank_we && bank_re) chk("we_re_overlap", 1, 0);
      if (tx_start) begin
        start_cnt++;
        chk("start_while_busy", int'(tx_busy), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_start", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("resp: tx_data=0x%02h expected=0x%02h cyc=%0d", tx_data, mon_e.resp, ncyc);
          chk("resp_byte", int'(tx_data), int'(mon_e.resp));
          if (mon_e.mode == 1) chk("resp_latency", ncyc - last_rx, mon_e.lat);
          if (mon_e.mode == 2) chk("resp_after_busy", ncyc - last_busy, 1);
        end
      end
      if (bank_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_bank_we", 1, 0);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", int'(bank_addr), int'(mon_w.a));
          chk("wr_data", int'(bank_wdata), int'(mon_w.d));
          chk("wr_latency", ncyc - last_rx, 1);
        end
      end
      if (bank_re) begin
        re_seen++;
        chk("re_latency", ncyc - last_rx, 1);
      end
      if (cmd_err) begin
        err_seen++;
        last_err = ncyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 4)) @(posedge clk);
  endtask

  task automatic check_counts();
    chk("err_count", err_seen, exp_err);
    chk("re_count", re_seen, exp_re);
  endtask

  // Reference model: derive the outcome of a frame from the frame rules,
  // record the expectations, then transmit the frame bytes.
  task automatic frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data);
    logic ok;
    ok = (addr < 8'd16);
    if (op == 8'h01) begin
      if (ok) begin
        exp_q.push_back('{8'hAA, 1, 2});
        wr_q.push_back('{addr[3:0], data});
        ref_mem[addr[3:0]] = data;
      end else begin
        exp_q.push_back('{8'hEE, 1, 1});
        exp_err++;
      end
      send_byte(op); gap(); send_byte(addr); gap(); send_byte(data);
    end else if (op == 8'h02) begin
      if (ok) begin
        exp_q.push_back('{ref_mem[addr[3:0]], 1, 3});
        exp_re++;
      end else begin
        exp_q.push_back('{8'hEE, 1, 1});
        exp_err++;
      end
      send_byte(op); gap(); send_byte(addr);
    end else if (op == 8'h03) begin
      exp_q.push_back('{8'h55, 1, 1});
      send_byte(op);
    end else begin
      exp_q.push_back('{8'hEE, 1, 1});
      exp_err++;
      send_byte(op);
    end
  endtask

  task automatic wait_done();
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (n < 400 && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (exp_q.size() == 0 && wr_q.size() == 0 && !tx_busy) ok = 1'b1;
    end
    chk("frame_drain", int'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
    check_counts();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_bank_addr"}, int'(bank_addr), 0);
    chk({tag, "_bank_wdata"}, int'(bank_wdata), 0);
    chk({tag, "_bank_we"}, int'(bank_we), 0);
    chk({tag, "_bank_re"}, int'(bank_re), 0);
    chk({tag, "_cmd_err"}, int'(cmd_err), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int n;
    int kind;
    logic [7:0] op, addr, data;

    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    nRst    = 1'b1;
    mem_clr = 1'b0;
    repeat (2) @(posedge clk);

    // Write then read back
    frame(8'h01, 8'h03, 8'h5A); wait_done();
    frame(8'h02, 8'h03, 8'h00); wait_done();

    // Bad opcode and out-of-range write address
    frame(8'h7F, 8'h00, 8'h00); wait_done();
    frame(8'h01, 8'h10, 8'h11); wait_done();
    frame(8'h02, 8'h80, 8'h00); wait_done();

    // Timeout: opcode with no follow-up, then a ping
    exp_err++;
    send_byte(8'h02);
    repeat (TIMEOUT + 20) @(posedge clk);
    #1;
    chk("timeout_latency", last_err - last_rx, TIMEOUT + 1);
    check_counts();
    frame(8'h03, 8'h00, 8'h00); wait_done();

    // Transmitter back-pressure across RESP entry
    force_busy = 1'b1;
    exp_q.push_back('{8'h55, 2, 0});
    send_byte(8'h03);
    repeat (50) @(posedge clk);
    #1;
    force_busy = 1'b0;
    wait_done();

    // Overrun: byte arriving while waiting for the transmitter to finish
    exp_q.push_back('{8'h55, 1, 1});
    s0 = start_cnt;
    send_byte(8'h03);
    n = 0;
    while (n < 20 && start_cnt == s0) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("overrun_start_seen", int'(start_cnt != s0), 1);
    force_busy = 1'b1;
    repeat (3) @(posedge clk);
    exp_err++;
    send_byte(8'h03);
    repeat (3) @(posedge clk);
    #1;
    force_busy = 1'b0;
    wait_done();
    frame(8'h03, 8'h00, 8'h00); wait_done();

    // Reset mid-frame
    send_byte(8'h01);
    gap();
    send_byte(8'h02);
    repeat (2) @(posedge clk);
    #1;
    nRst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    nRst = 1'b1;
    repeat (5) @(posedge clk);
    frame(8'h33, 8'h00, 8'h00); wait_done();

    // Random frames
    for (int f = 0; f < 40; f++) begin
      kind = int'($urandom_range(0, 6));
      addr = 8'($urandom_range(0, 15));
      data = 8'($urandom);
      case (kind)
        0, 1: op = 8'h01;
        2, 3: op = 8'h02;
        4:    op = 8'h03;
        5: begin op = 8'h01; addr = 8'($urandom_range(16, 255)); end
        default: begin
          op = 8'($urandom_range(4, 255));
        end
      endcase
      if (kind == 6 && $urandom_range(0, 1) == 1) op = 8'h00;
      frame(op, addr, data);
      wait_done();
    end

    chk("exp_left", exp_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
